audio_mixer: RTL and testbench
==============================

Name: audio_mixer

Overview:
Parametrised, time-multiplexed stereo mixer that generalises the fixed two-source PSG+PCM adder of the audio top to NUM_SRC sources, each with its own volume register. On each next_sample strobe it snapshots all sources, scales and accumulates one source per clock, then saturates and left-justifies the result. The stereo output feeds dacif as left_data/right_data.

Parameters:
NUM_SRC, 4, number of stereo sources (>=2)
IN_W, 16, signed sample width per source and channel
VOL_W, 4, unsigned volume width; unity gain = 2^(VOL_W-1)
OUT_W, 24, output width to DAC (>= IN_W)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
next_sample  in  1  single-cycle frame strobe
src_left  in  NUM_SRC*IN_W  packed signed left samples, src i at [i*IN_W +: IN_W]
src_right  in  NUM_SRC*IN_W  packed signed right samples, same packing
vol_addr  in  $clog2(NUM_SRC)  volume register index
vol_wrdata  in  VOL_W  volume write data
vol_write  in  1  volume write strobe
clear_flags  in  1  clears sticky flags
left_data  out  OUT_W  mixed left sample, MSB-justified
right_data  out  OUT_W  mixed right sample, MSB-justified
out_valid  out  1  one-cycle pulse when left/right_data update
busy  out  1  high while a frame is in progress
overrun  out  1  sticky: next_sample arrived while busy
clip_l  out  1  sticky left saturation flag (see Optional Feature)
clip_r  out  1  sticky right saturation flag (see Optional Feature)

Behaviour:
- Reset (async, immediate): state IDLE; left_data=right_data=0; out_valid=busy=overrun=clip_l=clip_r=0; all volume registers = 2^(VOL_W-1).
- Volume registers: on vol_write, vol[vol_addr] <= vol_wrdata on the next edge. Writes with vol_addr >= NUM_SRC are ignored. Writes are accepted in any state.
- States:
  - IDLE: on next_sample, snapshot src_left, src_right and all vol registers; clear both accumulators; set idx=0; go to ACCUM. busy=1 from the next cycle.
  - ACCUM: each cycle acc_x += snap_x[idx] * vol_snap[idx], signed IN_W x unsigned VOL_W. Accumulator width is IN_W+VOL_W+$clog2(NUM_SRC)+1, so it cannot overflow. idx++. After idx=NUM_SRC-1, go to SAT.
  - SAT: s_x = acc_x >>> (VOL_W-1), arithmetic shift, truncating toward -inf. Clamp s_x to [-2^(IN_W-1), 2^(IN_W-1)-1]. Register x_data = {clamped, (OUT_W-IN_W) zeros}. Pulse out_valid for one cycle. Go to IDLE; busy=0.
- Latency: next_sample at edge 0 gives out_valid high in cycle NUM_SRC+1 after the strobe edge, i.e. NUM_SRC+2 clocks per frame. The minimum frame spacing is NUM_SRC+2 clocks.
- left_data/right_data hold their value between frames.
- Volume writes during ACCUM/SAT affect the next frame only.
- A source sample change after the snapshot has no effect on the current frame.
- next_sample while busy: ignored, and overrun<=1. The frame in progress completes unaffected.
- next_sample in the same cycle as SAT (busy still high): ignored, and overrun is set.
- clear_flags clears overrun/clip_l/clip_r. If clear_flags and a set event coincide, the set wins.
- Volume 0 mutes a source. Volume 2^VOL_W-1 gives a gain of (2^VOL_W-1)/2^(VOL_W-1).
- Reset mid-frame aborts the frame. No out_valid is produced for the aborted frame.

Optional Feature:
Macro AUDIO_MIXER_CLIP_DETECT_EN.
- Defined: in SAT, clip_l/clip_r are set when the respective clamp actually limited the value. They stay sticky until clear_flags or rst.
- Not defined: clip_l and clip_r are tied to 0, and no clamp-detect logic is built. Saturation itself is always present.

Test Plan:
(All cases: NUM_SRC=4, IN_W=16, VOL_W=4, OUT_W=24.)
1. Reset, then next_sample with src0 L=0x1000, R=0xF000 and other sources 0 -> out_valid at cycle 5 after the strobe; left_data=0x100000, right_data=0xF00000; all vols read back as unity behaviour.
2. Saturation: all four L=0x7000 and all four R=0x9000 -> left_data=0x7FFF00, right_data=0x800000; with AUDIO_MIXER_CLIP_DETECT_EN, clip_l=clip_r=1, otherwise both 0.
3. Volume: write vol[1]=0 and vol[2]=15; src1 L=0x4000, src2 L=0x0800 -> left_data=0x0F0000. A write to vol_addr 4+ (if width allows) or during ACCUM does not alter the current frame.
4. Overrun: second next_sample 2 cycles after the first -> first frame result unchanged, only one out_valid, overrun=1; clear_flags pulse -> overrun=0.
5. Assert rst mid-ACCUM -> left/right_data=0, busy=0, out_valid never pulses for the aborted frame; vols return to 8; the next frame mixes correctly.
6. Back-to-back frames spaced exactly 6 clocks apart -> each accepted, overrun stays 0, outputs track each frame's inputs.

Source files
------------

// File: rtl/audio_mixer.sv
// Time-multiplexed NUM_SRC-source stereo mixer with per-source volume, saturation and MSB-justified output.
// Optional sticky clip detection is built when AUDIO_MIXER_CLIP_DETECT_EN is defined.
module audio_mixer #(
    parameter int NUM_SRC = 4,
    parameter int IN_W    = 16,
    parameter int VOL_W   = 4,
    parameter int OUT_W   = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       next_sample,
    input  logic [NUM_SRC*IN_W-1:0]    src_left,
    input  logic [NUM_SRC*IN_W-1:0]    src_right,
    input  logic [$clog2(NUM_SRC)-1:0] vol_addr,
    input  logic [VOL_W-1:0]           vol_wrdata,
    input  logic                       vol_write,
    input  logic                       clear_flags,
    output logic [OUT_W-1:0]           left_data,
    output logic [OUT_W-1:0]           right_data,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic                       clip_l,
    output logic                       clip_r
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int ACC_W = IN_W + VOL_W + IDX_W + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (IN_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [VOL_W-1:0]        UNITY   = VOL_W'(2 ** (VOL_W - 1));

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SAT} state_t;

    state_t                    r_state, w_state_next;
    logic                      w_start;
    logic [IDX_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]   r_acc_l, r_acc_r;
    logic [VOL_W-1:0]          r_vol      [NUM_SRC];
    logic [VOL_W-1:0]          r_vol_snap [NUM_SRC];
    logic signed [IN_W-1:0]    r_snap_l   [NUM_SRC];
    logic signed [IN_W-1:0]    r_snap_r   [NUM_SRC];

    logic signed [ACC_W-1:0]   w_gain, w_prod_l, w_prod_r, w_shift_l, w_shift_r;
    logic                      w_hi_l, w_lo_l, w_hi_r, w_lo_r;
    logic [IN_W-1:0]           w_clamp_l, w_clamp_r;

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: defaults come first so no path leaves an output unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (next_sample) begin
                    w_start      = 1'b1;
                    w_state_next = S_ACCUM;
                end
            end
            S_ACCUM: if (r_idx == IDX_W'(NUM_SRC - 1)) w_state_next = S_SAT;
            S_SAT:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) r_vol[i] <= UNITY;
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                if (vol_write && vol_addr == IDX_W'(i)) r_vol[i] <= vol_wrdata;
        end
    end

    // NOTE: snapshot storage is not reset; it is always written at frame start before it is read.
    always_ff @(posedge clk) begin
        if (w_start) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_snap_l[i]   <= src_left[i*IN_W +: IN_W];
                r_snap_r[i]   <= src_right[i*IN_W +: IN_W];
                r_vol_snap[i] <= r_vol[i];
            end
        end
    end

    // Volume is unsigned: zero-extend before the signed multiply.
    assign w_gain   = ACC_W'($signed({1'b0, r_vol_snap[r_idx]}));
    assign w_prod_l = ACC_W'(r_snap_l[r_idx]) * w_gain;
    assign w_prod_r = ACC_W'(r_snap_r[r_idx]) * w_gain;

    assign w_shift_l = r_acc_l >>> (VOL_W - 1);
    assign w_shift_r = r_acc_r >>> (VOL_W - 1);
    assign w_hi_l    = w_shift_l > SAT_MAX;
    assign w_lo_l    = w_shift_l < SAT_MIN;
    assign w_hi_r    = w_shift_r > SAT_MAX;
    assign w_lo_r    = w_shift_r < SAT_MIN;
    assign w_clamp_l = w_hi_l ? SAT_MAX[IN_W-1:0] : (w_lo_l ? SAT_MIN[IN_W-1:0] : w_shift_l[IN_W-1:0]);
    assign w_clamp_r = w_hi_r ? SAT_MAX[IN_W-1:0] : (w_lo_r ? SAT_MIN[IN_W-1:0] : w_shift_r[IN_W-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_acc_l    <= '0;
            r_acc_r    <= '0;
            left_data  <= '0;
            right_data <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (w_start) begin
                r_idx   <= '0;
                r_acc_l <= '0;
                r_acc_r <= '0;
            end else if (r_state == S_ACCUM) begin
                r_idx   <= r_idx + IDX_W'(1);
                r_acc_l <= r_acc_l + w_prod_l;
                r_acc_r <= r_acc_r + w_prod_r;
            end else if (r_state == S_SAT) begin
                left_data  <= OUT_W'(w_clamp_l) << (OUT_W - IN_W);
                right_data <= OUT_W'(w_clamp_r) << (OUT_W - IN_W);
                out_valid  <= 1'b1;
            end
        end
    end

    // Sticky flags: a set event in the same cycle as clear_flags wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      overrun <= 1'b0;
        else if (next_sample && busy) overrun <= 1'b1;
        else if (clear_flags)         overrun <= 1'b0;
    end

`ifdef AUDIO_MIXER_CLIP_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_l <= 1'b0;
            clip_r <= 1'b0;
        end else begin
            if (r_state == S_SAT && (w_hi_l || w_lo_l)) clip_l <= 1'b1;
            else if (clear_flags)                       clip_l <= 1'b0;
            if (r_state == S_SAT && (w_hi_r || w_lo_r)) clip_r <= 1'b1;
            else if (clear_flags)                       clip_r <= 1'b0;
        end
    end
`else
    assign clip_l = 1'b0;
    assign clip_r = 1'b0;
`endif

endmodule

// File: tb/tb_audio_mixer.sv
// Directed self-checking bench for audio_mixer (NUM_SRC=4, IN_W=16, VOL_W=4, OUT_W=24).
module tb_audio_mixer;
    localparam int NUM_SRC = 4;
    localparam int IN_W    = 16;
    localparam int VOL_W   = 4;
    localparam int OUT_W   = 24;
`ifdef AUDIO_MIXER_CLIP_DETECT_EN
    localparam logic CLIP_EXP = 1'b1;
`else
    localparam logic CLIP_EXP = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst, next_sample, vol_write, clear_flags;
    logic [NUM_SRC*IN_W-1:0] src_left, src_right;
    logic [1:0]              vol_addr;
    logic [VOL_W-1:0]        vol_wrdata;
    logic [OUT_W-1:0]        left_data, right_data;
    logic                    out_valid, busy, overrun, clip_l, clip_r;

    int               n_checks = 0;
    int               n_fail   = 0;
    int               lat, pulses;
    logic [OUT_W-1:0] cap_l;

    always #5 clk = ~clk;

    audio_mixer #(.NUM_SRC(NUM_SRC), .IN_W(IN_W), .VOL_W(VOL_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .next_sample(next_sample),
        .src_left(src_left), .src_right(src_right),
        .vol_addr(vol_addr), .vol_wrdata(vol_wrdata), .vol_write(vol_write),
        .clear_flags(clear_flags),
        .left_data(left_data), .right_data(right_data), .out_valid(out_valid),
        .busy(busy), .overrun(overrun), .clip_l(clip_l), .clip_r(clip_r)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_src();
        src_left  = '0;
        src_right = '0;
    endtask

    task automatic set_src(input int i, input logic [IN_W-1:0] l, input logic [IN_W-1:0] r);
        src_left[i*IN_W +: IN_W]  = l;
        src_right[i*IN_W +: IN_W] = r;
    endtask

    task automatic strobe();
        next_sample = 1'b1;
        step();
        next_sample = 1'b0;
    endtask

    task automatic write_vol(input logic [1:0] a, input logic [VOL_W-1:0] d);
        vol_addr   = a;
        vol_wrdata = d;
        vol_write  = 1'b1;
        step();
        vol_write  = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
    endtask

    // Returns cycles waited; bounded so a missing out_valid cannot hang the run.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic count_pulses(input int ncyc, output int p);
        p = 0;
        repeat (ncyc) begin
            step();
            if (out_valid) p++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; next_sample = 1'b0; vol_write = 1'b0; clear_flags = 1'b0;
        vol_addr = '0; vol_wrdata = '0;
        clear_src();
        repeat (2) step();
        check("rst_left", left_data, 0);
        check("rst_right", right_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_clip", {clip_l, clip_r}, 0);
        rst = 1'b0;
        step();

        // 1: single source at unity gain, latency 5
        set_src(0, 16'h1000, 16'hF000);
        strobe();
        check("t1_busy", busy, 1);
        wait_valid(lat);
        check("t1_latency", lat, 5);
        check("t1_left", left_data, 24'h100000);
        check("t1_right", right_data, 24'hF00000);
        step();
        check("t1_valid_one_cycle", out_valid, 0);
        check("t1_busy_done", busy, 0);
        check("t1_left_hold", left_data, 24'h100000);

        // 2: positive and negative saturation
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 16'h7000, 16'h9000);
        strobe();
        wait_valid(lat);
        check("t2_left", left_data, 24'h7FFF00);
        check("t2_right", right_data, 24'h800000);
        check("t2_clip_l", clip_l, CLIP_EXP);
        check("t2_clip_r", clip_r, CLIP_EXP);
        pulse_clear();
        check("t2_clip_cleared", {clip_l, clip_r}, 0);

        // 3: mute, max gain, mid-frame volume write and source change
        write_vol(2'd1, 4'd0);
        write_vol(2'd2, 4'd15);
        clear_src();
        set_src(1, 16'h4000, 16'h0000);
        set_src(2, 16'h0800, 16'h0000);
        strobe();
        step();
        write_vol(2'd2, 4'd8);
        set_src(2, 16'h7FFF, 16'h0000);
        wait_valid(lat);
        check("t3_latency", lat, 3);
        check("t3_left", left_data, 24'h0F0000);
        check("t3_right", right_data, 24'h000000);
        check("t3_no_clip", {clip_l, clip_r}, 0);
        set_src(2, 16'h0800, 16'h0000);
        strobe();
        wait_valid(lat);
        check("t3_next_frame_left", left_data, 24'h080000);
        // -1 at gain 1/8 floors to -1; +7 at gain 1/8 floors to 0
        clear_src();
        set_src(3, 16'hFFFF, 16'h0007);
        write_vol(2'd3, 4'd1);
        strobe();
        wait_valid(lat);
        check("t3_floor_left", left_data, 24'hFFFF00);
        check("t3_floor_right", right_data, 24'h000000);
        write_vol(2'd3, 4'd8);

        // 4: overrun during ACCUM
        clear_src();
        set_src(0, 16'h2000, 16'h0000);
        strobe();
        step();
        next_sample = 1'b1;
        set_src(0, 16'h1234, 16'h0000);
        step();
        next_sample = 1'b0;
        pulses = 0;
        cap_l  = '0;
        repeat (10) begin
            if (out_valid) begin
                pulses++;
                cap_l = left_data;
            end
            step();
        end
        check("t4_pulses", pulses, 1);
        check("t4_left", cap_l, 24'h200000);
        check("t4_overrun", overrun, 1);
        pulse_clear();
        check("t4_overrun_cleared", overrun, 0);

        // 4b: strobe during SAT together with clear_flags: ignored, set wins
        set_src(0, 16'h0400, 16'h0000);
        strobe();
        repeat (4) step();
        next_sample = 1'b1;
        clear_flags = 1'b1;
        step();
        next_sample = 1'b0;
        clear_flags = 1'b0;
        check("t4b_valid", out_valid, 1);
        check("t4b_left", left_data, 24'h040000);
        check("t4b_overrun_set_wins", overrun, 1);
        count_pulses(8, pulses);
        check("t4b_no_extra_frame", pulses, 0);
        pulse_clear();

        // 5: reset mid-ACCUM aborts the frame and restores volumes
        set_src(0, 16'h3000, 16'h3000);
        strobe();
        repeat (2) step();
        rst = 1'b1;
        #1;
        check("t5_busy", busy, 0);
        check("t5_left", left_data, 0);
        check("t5_right", right_data, 0);
        step();
        rst = 1'b0;
        count_pulses(10, pulses);
        check("t5_no_valid", pulses, 0);
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 16'h0100, 16'hFF00);
        strobe();
        wait_valid(lat);
        check("t5_latency", lat, 5);
        check("t5_mix_left", left_data, 24'h040000);
        check("t5_mix_right", right_data, 24'hFC0000);

        // 6: back-to-back frames at the minimum spacing of 6 clocks
        clear_src();
        set_src(0, 16'h0100, 16'h0200);
        strobe();
        wait_valid(lat);
        check("t6a_latency", lat, 5);
        check("t6a_left", left_data, 24'h010000);
        check("t6a_right", right_data, 24'h020000);
        clear_src();
        set_src(1, 16'hFF00, 16'h0010);
        strobe();
        wait_valid(lat);
        check("t6b_latency", lat, 5);
        check("t6b_left", left_data, 24'hFF0000);
        check("t6b_right", right_data, 24'h001000);
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 16'h1000, 16'h0001);
        strobe();
        wait_valid(lat);
        check("t6c_latency", lat, 5);
        check("t6c_left", left_data, 24'h400000);
        check("t6c_right", right_data, 24'h000400);
        check("t6_overrun", overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
